// File: rtl/memstage_pkg.sv
// rtl/memstage_pkg.sv - shared types and helpers for the memory-access stage
package memstage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int LANE_W = 2;
  localparam int BYTE_W = 8;

  // Little-endian lanes: lane n occupies bits [8n+7:8n].
  function automatic logic [4:0] lane_shift(input logic [LANE_W-1:0] lane);
    return {lane, 3'b000};
  endfunction

endpackage

// File: rtl/byte_lane_unit.sv
// rtl/byte_lane_unit.sv - byte extract and byte merge for one 32-bit word
module byte_lane_unit
  import memstage_pkg::*;
(
  input  logic [31:0]       word_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [31:0]       extracted_o,
  output logic [31:0]       merged_o
);

  logic [31:0] lane_mask;

  assign lane_mask   = 32'h0000_00FF << lane_shift(lane_i);
  assign extracted_o = word_i >> lane_shift(lane_i);
  assign merged_o    = (word_i & ~lane_mask) | ({24'd0, byte_i} << lane_shift(lane_i));

endmodule

// File: rtl/memstage_ctrl.sv
// rtl/memstage_ctrl.sv - word/byte load-store controller with read-modify-write byte stores
module memstage_ctrl
  import memstage_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic              WrOp,
  input  logic              ByteOp,
  input  logic [31:0]       ALU_MEM_Addr,
  input  logic [31:0]       MEM_DataIn,
  output logic [31:0]       MEM_out,
  output logic              Done,
  output logic              Err,
  output logic              Busy,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [31:0]       Mem_WData,
  input  logic [31:0]       Mem_RData,
  input  logic              Mem_Ack
);

  state_e              state_q, state_d;
  logic                wr_q, wr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [BYTE_W-1:0]   din_q, din_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         out_q, out_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [31:0]         extracted;
  logic [31:0]         merged;
  logic                timed_out;
  logic                unused_addr_hi;

  assign unused_addr_hi = ^ALU_MEM_Addr[31:ADDR_W+2];

  // One lane unit serves both the load extract and the byte-store merge.
  byte_lane_unit u_lane (
    .word_i      (Mem_RData),
    .lane_i      (lane_q),
    .byte_i      (din_q),
    .extracted_o (extracted),
    .merged_o    (merged)
  );

  assign timed_out = (cnt_q == 8'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    lane_d  = lane_q;
    din_d   = din_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    out_d   = out_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          wr_d   = WrOp;
          lane_d = ALU_MEM_Addr[1:0];
          din_d  = MEM_DataIn[7:0];
          addr_d = ALU_MEM_Addr[ADDR_W+1:2];
          err_d  = 1'b0;
          cnt_d  = 8'd0;
          if (!ByteOp && ALU_MEM_Addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_FIN;
          end else if (WrOp && !ByteOp) begin
            wdata_d = MEM_DataIn;
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (Mem_Ack) begin
          if (wr_q) begin
            wdata_d = merged;
            cnt_d   = 8'd0;
            state_d = ST_WR;
          end else begin
            out_d   = extracted;
            state_d = ST_FIN;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WR: begin
        if (Mem_Ack) begin
          state_d = ST_FIN;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      lane_q  <= '0;
      din_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      lane_q  <= lane_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      out_q   <= out_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Mem_Req   = (state_q == ST_RD) || (state_q == ST_WR);
  assign Mem_We    = (state_q == ST_WR);
  assign Done      = (state_q == ST_FIN);
  assign Err       = Done && err_q;
  assign Mem_Addr  = addr_q;
  assign Mem_WData = wdata_q;
  assign MEM_out   = out_q;

endmodule

// File: tb/tb_memstage_ctrl.sv
// tb/tb_memstage_ctrl.sv - directed bench for memstage_ctrl against a small word memory
module tb_memstage_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Start = 1'b0;
  logic        WrOp = 1'b0;
  logic        ByteOp = 1'b0;
  logic [31:0] ALU_MEM_Addr = '0;
  logic [31:0] MEM_DataIn = '0;
  logic [31:0] MEM_out;
  logic        Done, Err, Busy, Mem_Req, Mem_We;
  logic [9:0]  Mem_Addr;
  logic [31:0] Mem_WData, Mem_RData;
  logic        Mem_Ack;

  logic [31:0] mem [16];
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          wcnt = 0;
  logic        pl_en = 1'b0;
  logic [3:0]  pl_a = '0;
  logic [31:0] pl_d = '0;

  int vec = 0;
  int miss = 0;

  always #5 Clk = ~Clk;

  memstage_ctrl #(.ADDR_W(10), .TIMEOUT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .WrOp(WrOp), .ByteOp(ByteOp),
    .ALU_MEM_Addr(ALU_MEM_Addr), .MEM_DataIn(MEM_DataIn), .MEM_out(MEM_out),
    .Done(Done), .Err(Err), .Busy(Busy), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_RData(Mem_RData), .Mem_Ack(Mem_Ack)
  );

  assign Mem_RData = mem[Mem_Addr[3:0]];
  assign Mem_Ack   = ack_en && Mem_Req && (wcnt >= ack_delay);

  always @(posedge Clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (Mem_Req && Mem_We && Mem_Ack) mem[Mem_Addr[3:0]] <= Mem_WData;
    if (Mem_Req && !Mem_Ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic poke(input logic [3:0] a, input logic [31:0] d);
    @(negedge Clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge Clk); #1;
    pl_en = 1'b0;
  endtask

  // Cycle 1 is the cycle after the Start-sampling edge; returns in the Done cycle.
  task automatic do_access(input logic wr, input logic by, input logic [31:0] a, input logic [31:0] d,
                           output int done_cyc, output logic err_o, output int req_n,
                           output int we_n, output logic [31:0] wd, output logic [9:0] ma);
    repeat (2) @(negedge Clk);
    Start = 1'b1; WrOp = wr; ByteOp = by; ALU_MEM_Addr = a; MEM_DataIn = d;
    @(posedge Clk); #1;
    Start = 1'b0;
    done_cyc = -1; err_o = 1'b0; req_n = 0; we_n = 0; wd = '0; ma = '0;
    for (int k = 1; k <= 40; k++) begin
      if (Mem_Req) begin req_n++; ma = Mem_Addr; end
      if (Mem_We) begin we_n++; wd = Mem_WData; end
      if (Done) begin done_cyc = k; err_o = Err; break; end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset();
    #3;
    vec++; if ({Done, Err, Busy, Mem_Req, Mem_We} !== 5'b0) begin miss++; $display("FAIL reset_flags got=%b exp=00000", {Done, Err, Busy, Mem_Req, Mem_We}); end
    vec++; if (Mem_Addr !== 10'd0) begin miss++; $display("FAIL reset_addr got=%h exp=0", Mem_Addr); end
    vec++; if (Mem_WData !== 32'd0) begin miss++; $display("FAIL reset_wdata got=%h exp=0", Mem_WData); end
    vec++; if (MEM_out !== 32'd0) begin miss++; $display("FAIL reset_memout got=%h exp=0", MEM_out); end
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_word_load();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    poke(4'd4, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, dc, e, rq, we, wd, ma);
    vec++; if (dc !== 2) begin miss++; $display("FAIL wload_done_cycle got=%0d exp=2", dc); end
    vec++; if (ma !== 10'd4) begin miss++; $display("FAIL wload_addr got=%0d exp=4", ma); end
    vec++; if (we !== 0 || e !== 1'b0) begin miss++; $display("FAIL wload_we_err got=%0d/%b exp=0/0", we, e); end
    vec++; if (MEM_out !== 32'hDEAD_BEEF) begin miss++; $display("FAIL wload_data got=%h exp=deadbeef", MEM_out); end
  endtask

  task automatic test_byte_load();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    poke(4'd4, 32'h1122_3344);
    do_access(1'b0, 1'b1, 32'h0000_0013, 32'h0, dc, e, rq, we, wd, ma);
    vec++; if (dc !== 2 || MEM_out !== 32'h0000_0011) begin miss++; $display("FAIL bload_lane3 got=%h@%0d exp=00000011@2", MEM_out, dc); end
    do_access(1'b0, 1'b1, 32'h0000_0011, 32'h0, dc, e, rq, we, wd, ma);
    vec++; if (MEM_out !== 32'h0011_2233 || e !== 1'b0) begin miss++; $display("FAIL bload_lane1 got=%h err=%b exp=00112233 err=0", MEM_out, e); end
  endtask

  task automatic test_byte_store();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    do_access(1'b1, 1'b1, 32'h0000_0011, 32'hFFFF_FFAB, dc, e, rq, we, wd, ma);
    vec++; if (dc !== 3) begin miss++; $display("FAIL bstore_done_cycle got=%0d exp=3", dc); end
    vec++; if (rq !== 2 || we !== 1) begin miss++; $display("FAIL bstore_phases got req=%0d we=%0d exp req=2 we=1", rq, we); end
    vec++; if (wd !== 32'h1122_AB44) begin miss++; $display("FAIL bstore_wdata got=%h exp=1122ab44", wd); end
    vec++; if (MEM_out !== 32'h0011_2233) begin miss++; $display("FAIL bstore_memout got=%h exp=00112233", MEM_out); end
    vec++; if (mem[4] !== 32'h1122_AB44) begin miss++; $display("FAIL bstore_mem got=%h exp=1122ab44", mem[4]); end
  endtask

  task automatic test_word_store();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    do_access(1'b1, 1'b0, 32'h0000_0020, 32'hCAFE_F00D, dc, e, rq, we, wd, ma);
    vec++; if (dc !== 2 || we !== 1 || ma !== 10'd8) begin miss++; $display("FAIL wstore_timing got done=%0d we=%0d addr=%0d exp 2/1/8", dc, we, ma); end
    vec++; if (mem[8] !== 32'hCAFE_F00D) begin miss++; $display("FAIL wstore_mem got=%h exp=cafef00d", mem[8]); end
  endtask

  task automatic test_misaligned();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    do_access(1'b1, 1'b0, 32'h0000_0012, 32'h5555_5555, dc, e, rq, we, wd, ma);
    vec++; if (dc !== 1 || e !== 1'b1) begin miss++; $display("FAIL misalign_done got=%0d err=%b exp=1 err=1", dc, e); end
    vec++; if (rq !== 0) begin miss++; $display("FAIL misalign_req got=%0d exp=0", rq); end
    vec++; if (MEM_out !== 32'h0011_2233) begin miss++; $display("FAIL misalign_memout got=%h exp=00112233", MEM_out); end
  endtask

  task automatic test_wait_states();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    ack_delay = 2;
    do_access(1'b0, 1'b0, 32'h0000_0020, 32'h0, dc, e, rq, we, wd, ma);
    ack_delay = 0;
    vec++; if (dc !== 4 || rq !== 3 || e !== 1'b0) begin miss++; $display("FAIL wait_load got done=%0d req=%0d err=%b exp 4/3/0", dc, rq, e); end
    vec++; if (MEM_out !== 32'hCAFE_F00D) begin miss++; $display("FAIL wait_data got=%h exp=cafef00d", MEM_out); end
  endtask

  task automatic test_timeout();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    ack_en = 1'b0;
    do_access(1'b1, 1'b1, 32'h0000_0010, 32'h0000_0077, dc, e, rq, we, wd, ma);
    ack_en = 1'b1;
    vec++; if (rq !== 4 || dc !== 5 || e !== 1'b1) begin miss++; $display("FAIL timeout got req=%0d done=%0d err=%b exp 4/5/1", rq, dc, e); end
    vec++; if (we !== 0 || mem[4] !== 32'h1122_AB44) begin miss++; $display("FAIL timeout_nowrite got we=%0d mem=%h exp 0/1122ab44", we, mem[4]); end
    do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, dc, e, rq, we, wd, ma);
    vec++; if (dc !== 2 || e !== 1'b0 || MEM_out !== 32'h1122_AB44) begin miss++; $display("FAIL after_timeout got done=%0d err=%b data=%h exp 2/0/1122ab44", dc, e, MEM_out); end
  endtask

  task automatic test_back_to_back();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    do_access(1'b0, 1'b0, 32'h0000_0020, 32'h0, dc, e, rq, we, wd, ma);
    @(negedge Clk);
    Start = 1'b1; WrOp = 1'b0; ByteOp = 1'b0; ALU_MEM_Addr = 32'h0000_0010;
    @(posedge Clk); #1;
    Start = 1'b0;
    vec++; if (Busy !== 1'b0 || Mem_Req !== 1'b0) begin miss++; $display("FAIL start_on_done got busy=%b req=%b exp 0/0", Busy, Mem_Req); end
    vec++; if (MEM_out !== 32'hCAFE_F00D) begin miss++; $display("FAIL start_on_done_data got=%h exp=cafef00d", MEM_out); end
  endtask

  task automatic test_reset_mid();
    int dc, rq, we; logic e; logic [31:0] wd; logic [9:0] ma;
    int done_seen = 0;
    ack_en = 1'b0;
    @(negedge Clk);
    Start = 1'b1; WrOp = 1'b0; ByteOp = 1'b1; ALU_MEM_Addr = 32'h0000_0013;
    @(posedge Clk); #1;
    Start = 1'b0;
    @(posedge Clk); #1;
    vec++; if (Mem_Req !== 1'b1 || Busy !== 1'b1) begin miss++; $display("FAIL midreset_pre got req=%b busy=%b exp 1/1", Mem_Req, Busy); end
    Reset_n = 1'b0;
    #1;
    vec++; if (Mem_Req !== 1'b0 || Busy !== 1'b0 || MEM_out !== 32'd0) begin miss++; $display("FAIL midreset_clear got req=%b busy=%b out=%h exp 0/0/0", Mem_Req, Busy, MEM_out); end
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    ack_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clk); #1;
      if (Done) done_seen++;
    end
    vec++; if (done_seen !== 0) begin miss++; $display("FAIL midreset_nodone got=%0d exp=0", done_seen); end
    do_access(1'b0, 1'b0, 32'h0000_0010, 32'h0, dc, e, rq, we, wd, ma);
    vec++; if (dc !== 2 || MEM_out !== 32'h1122_AB44) begin miss++; $display("FAIL midreset_after got done=%0d data=%h exp 2/1122ab44", dc, MEM_out); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_byte_store();
    test_word_store();
    test_misaligned();
    test_wait_states();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/memstage_ctrl.md
# memstage_ctrl

Memory-access stage controller for the multicycle datapath. It receives the effective address from the ALU and the store data from RF_B. It runs word or byte loads and stores against a single-ported, word-wide data memory over a request/acknowledge handshake, and returns load data as MEM_out to the decode stage's write-back path. Byte stores are performed as read-modify-write because the memory has no byte enables.

## Interface
Parameters:
- ADDR_W, 10: word-address width toward memory; byte address bits [ADDR_W+1:2] form the word address.
- TIMEOUT, 16: maximum number of request cycles without acknowledge before the access aborts; range 2..255.

Ports:
- Clk, in, 1: the block's single clock, rising-edge.
- Reset_n, in, 1: asynchronous, active-low reset.
- Start, in, 1: one-cycle pulse that starts an access; sampled only in IDLE.
- WrOp, in, 1: 1 = store, 0 = load.
- ByteOp, in, 1: 1 = byte access, 0 = word access.
- ALU_MEM_Addr, in, 32: byte address.
- MEM_DataIn, in, 32: store data, taken from RF_B; byte stores use bits [7:0].
- MEM_out, out, 32: load result; valid while Done = 1 and held until the next Start.
- Done, out, 1: one-cycle completion pulse.
- Err, out, 1: qualified by Done; 1 = misaligned word access or timeout.
- Busy, out, 1: 1 in every state except IDLE.
- Mem_Req, out, 1: memory request.
- Mem_We, out, 1: write request.
- Mem_Addr, out, ADDR_W: word address.
- Mem_WData, out, 32: write data.
- Mem_RData, in, 32: read data; valid in the cycle Mem_Ack = 1.
- Mem_Ack, in, 1: memory acknowledge.

## Operation
- **Input capture:** Start in IDLE latches WrOp, ByteOp, the address and the data. The byte lane is `lane = Addr[1:0]`, little-endian (lane 0 = bits 7:0). Start outside IDLE is ignored.
- **States:** IDLE, RD, WR, FIN.
- **Misaligned word access** (ByteOp = 0, lane ≠ 0): IDLE → FIN with Err = 1. No memory request is issued. MEM_out is unchanged.
- **Word load:** IDLE → RD. On Ack, capture `MEM_out = Mem_RData`, then → FIN.
- **Byte load:** IDLE → RD. On Ack, capture `MEM_out = Mem_RData >> (8*lane)`, a logical shift, then → FIN. The decode stage zero-extends bits [7:0].
- **Word store:** IDLE → WR with `Mem_WData = MEM_DataIn`. On Ack → FIN.
- **Byte store:** IDLE → RD. On Ack, capture the read word, build the merged word (the read word with lane `lane` replaced by `MEM_DataIn[7:0]`), then → WR. On Ack → FIN. MEM_out is not updated by any store.
- **FIN:** Done = 1 for one cycle, then → IDLE.
- **Timeout counter:**
  - Cleared on entering RD or WR.
  - Incremented each cycle with Mem_Req = 1 and Mem_Ack = 0.
  - When TIMEOUT request cycles have passed without Ack, the state goes → FIN with Err = 1. Req drops, and no further memory phase is started; for a byte store, the write is skipped.
- **Reset_n = 0:**
  - Immediately forces the state to IDLE.
  - Clears all outputs: MEM_out = 0, Done = 0, Err = 0, Busy = 0, Mem_Req = 0, Mem_We = 0, Mem_Addr = 0, Mem_WData = 0.
  - Clears the timeout counter.
  - A reset during an access produces no Done; the memory sees Req fall.

## Timing
- Mem_Req = 1 exactly in RD and WR.
- Mem_We = 1 exactly in WR.
- Mem_Addr and Mem_WData are registered and stable for the whole time Req = 1.
- Ack is honoured only on a clock edge where Req = 1. The earliest Ack is in the first request cycle; Ack seen while Req = 0 is ignored.
- Minimum latency, counting the Start-sampling edge as edge 0:
  - Word access: Req in cycle 1, Ack in cycle 1, Done in cycle 2.
  - Byte store: read in cycle 1, write in cycle 2, Done in cycle 3.
  - Misaligned access: Done + Err in cycle 1.
- For each extra wait cycle on Ack, Done moves one cycle later.
- On timeout, Done + Err appear in the cycle after the TIMEOUT-th unacknowledged request cycle.
- Between consecutive phases of a byte store, Req stays high; WR follows RD with no idle cycle.
- A Start coincident with Done is ignored, because the state is FIN, not IDLE. The next Start is accepted one cycle after Done.

## Structure
- **Shared package `memstage_pkg`:**
  - State encoding constants for IDLE, RD, WR and FIN (2 bits).
  - LANE_W = 2.
  - BYTE_W = 8.
  - A function or constant for the lane shift amount.
- **Sub-module `byte_lane_unit` (combinational):**
  - Inputs: word, lane, byte.
  - Outputs: extracted (word >> 8*lane) and merged (word with lane replaced).
  - Instantiated once; shared by the load path and the byte-store path.
- **Top level:** the FSM, operand registers, timeout counter and output registers.

## Test plan
- **Word load:** Addr = 0x0000_0010, memory word 4 = 0xDEAD_BEEF, Ack in the first Req cycle → Mem_Addr = 4, Mem_We = 0, Done at cycle 2, MEM_out = 0xDEAD_BEEF, Err = 0.
- **Byte load:** Addr = 0x0000_0013, word 4 = 0x1122_3344 → MEM_out[7:0] = 0x11, MEM_out = 0x0000_0011.
- **Byte store read-modify-write:** Addr = 0x0000_0011, MEM_DataIn = 0xFFFF_FFAB, word 4 = 0x1122_3344 → read phase, then write phase with Mem_WData = 0x1122_AB44, Mem_We = 1 only in the write phase, Done at cycle 3.
- **Misaligned word store:** Addr = 0x0000_0012 → Mem_Req never rises, Done = 1 and Err = 1 at cycle 1.
- **Timeout:** TIMEOUT = 4, Ack held at 0 → Req high for exactly 4 cycles, then Done = 1 and Err = 1. A subsequent access with normal Ack succeeds.
- **Reset mid-access:** Ack held off, Reset_n pulsed low during RD → Req, Busy and MEM_out clear asynchronously, no Done. Start after reset release is accepted normally.
